// File: rtl/hex_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hex_counter_pkg
//  Description : Shared definitions for the hex display counter. Holds the
//                rate-select encodings, the divider period for each rate,
//                and the divider register width.
//  Revision    : 1.0 - initial release
// ============================================================================
package hex_counter_pkg;

    // Rate-select encodings for the 2-bit speed input.
    localparam logic [1:0] SPD_FAST    = 2'b00;  // step on every enabled cycle
    localparam logic [1:0] SPD_1HZ     = 2'b01;  // step every CLK_HZ cycles
    localparam logic [1:0] SPD_HALF    = 2'b10;  // step every 2*CLK_HZ cycles
    localparam logic [1:0] SPD_QUARTER = 2'b11;  // step every 4*CLK_HZ cycles

    // Number of enabled clock cycles between two steps at a given rate.
    function automatic int unsigned period(input logic [1:0] spd,
                                           input int unsigned clk_hz);
        int unsigned p;
        case (spd)
            SPD_FAST: p = 1;
            SPD_1HZ:  p = clk_hz;
            SPD_HALF: p = 2 * clk_hz;
            default:  p = 4 * clk_hz;
        endcase
        return p;
    endfunction

    // Divider width: wide enough to hold the longest reload value,
    // 4*CLK_HZ-1. Floored at one bit so degenerate clocks still elaborate.
    function automatic int unsigned div_width(input int unsigned clk_hz);
        int unsigned w;
        w = $clog2(4 * clk_hz);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : hex_counter_pkg
`default_nettype wire

// File: rtl/hex_counter_rate_divider.sv
`default_nettype none
// ============================================================================
//  Module      : rate_divider
//  Description : Down-counting rate divider for the hex display counter.
//                Holds the divider count and the rate currently applied.
//                A restart or a rate change reloads a full period; otherwise
//                the count runs only while enabled and reloads when it
//                expires.
//  Ports       : clk      - system clock
//                reset    - asynchronous active-high reset
//                enable   - divider runs when high, holds when low
//                speed    - requested rate select
//                restart  - reload strobe (parallel load of the counter)
//                pulse    - high in the cycle whose rising edge is a step
//  Revision    : 1.0 - initial release
// ============================================================================
module rate_divider
    import hex_counter_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] speed,
    input  logic       restart,
    output logic       pulse
);

    localparam int unsigned c_cw = div_width(CLK_HZ);

    logic [c_cw-1:0] r_cnt;
    logic [1:0]      r_speed_q;
    logic            w_rate_change;
    logic            w_expired;

    // Reload value for a rate: one less than its period, since the step
    // happens on the edge where the count is already zero.
    function automatic logic [c_cw-1:0] reload_of(input logic [1:0] spd);
        return c_cw'(period(spd, CLK_HZ) - 1);
    endfunction

    assign w_rate_change = (speed != r_speed_q);
    assign w_expired     = (r_cnt == '0);

    // A step is suppressed whenever this same edge is busy reloading,
    // whether because of a restart or a rate change.
    assign pulse = enable && w_expired && !restart && !w_rate_change;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_speed_q <= SPD_FAST;
        end else if (restart || w_rate_change) begin
            // A new rate always begins with a full period.
            r_cnt     <= reload_of(speed);
            r_speed_q <= speed;
        end else if (enable) begin
            if (w_expired) begin
                r_cnt <= reload_of(r_speed_q);
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule : rate_divider
`default_nettype wire

// File: rtl/hex_counter.sv
`default_nettype none
// ============================================================================
//  Module      : hex_counter
//  Description : 4-bit free-running display counter with selectable step
//                rate, direction and parallel load. The value wraps through
//                0..F and feeds a 7-segment decoder directly.
//  Ports       : clk      - system clock
//                reset    - asynchronous active-high reset
//                enable   - run/hold for divider and counter
//                speed    - rate select (every cycle, 1 Hz, 0.5 Hz, 0.25 Hz)
//                up       - 1 = count up, 0 = count down
//                load     - synchronous parallel load strobe
//                load_val - value written on load
//                value    - current count
//                tick     - one-cycle pulse aligned with each new value
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_counter
    import hex_counter_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] speed,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] value,
    output logic       tick
);

    logic       w_step;
    logic [3:0] w_next;
    logic [3:0] r_value;
    logic       r_tick;

    rate_divider #(
        .CLK_HZ (CLK_HZ)
    ) u_rate_divider (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .speed   (speed),
        .restart (load),
        .pulse   (w_step)
    );

    // Modulo-16 wrap comes for free from the 4-bit width.
    assign w_next = up ? (r_value + 4'd1) : (r_value - 4'd1);

    // Load outranks a step; the divider already masks its pulse on load,
    // but the explicit ordering keeps the loaded value from being stepped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_value <= 4'h0;
            r_tick  <= 1'b0;
        end else if (load) begin
            r_value <= load_val;
            r_tick  <= 1'b0;
        end else if (w_step) begin
            r_value <= w_next;
            r_tick  <= 1'b1;
        end else begin
            r_tick  <= 1'b0;
        end
    end

    assign value = r_value;
    assign tick  = r_tick;

endmodule : hex_counter
`default_nettype wire

// File: tb/tb_hex_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hex_counter
//  Description : Self-checking bench for hex_counter at CLK_HZ=4. Uses an
//                elapsed-cycles reference model, a vector table, directed
//                corner sequences and a randomized run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_counter;

    localparam int unsigned CLK_HZ = 4;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [1:0] speed;
    logic       up;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] value;
    logic       tick;

    int total = 0;
    int bad   = 0;

    // Reference model: counts enabled cycles elapsed in the current period.
    int m_val;
    int m_el;
    int m_spd;
    int m_tick;

    hex_counter #(
        .CLK_HZ (CLK_HZ)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .speed    (speed),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .value    (value),
        .tick     (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic [3:0] lv;
        logic [1:0] spd;
        logic       up;
        logic       en;
        logic [3:0] ev;
        logic       et;
    } vec_t;

    vec_t tbl [14];

    function automatic int pf(input int s);
        return (s == 0) ? 1 : (CLK_HZ << (s - 1));
    endfunction

    function automatic void model_reset();
        m_val = 0; m_el = 0; m_spd = 0; m_tick = 0;
    endfunction

    function automatic void model_edge();
        if (load) begin
            m_val = int'(load_val); m_el = 0; m_spd = int'(speed); m_tick = 0;
        end else if (int'(speed) != m_spd) begin
            m_el = 0; m_spd = int'(speed); m_tick = 0;
        end else if (enable) begin
            if (m_el == pf(m_spd) - 1) begin
                m_val  = (m_val + (up ? 1 : 15)) % 16;
                m_el   = 0;
                m_tick = 1;
            end else begin
                m_el++;
                m_tick = 0;
            end
        end else begin
            m_tick = 0;
        end
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // One clock: model advances on the edge with the pre-edge inputs;
    // returns 2 time units after the edge with outputs settled.
    task automatic clk_edge();
        @(posedge clk);
        model_edge();
        #2;
    endtask

    task automatic cyc_chk();
        clk_edge();
        chk("model_value", int'(value), m_val);
        chk("model_tick", int'(tick), m_tick);
    endtask

    task automatic wait_tick(input int lim, output int n);
        n = 0;
        do begin
            cyc_chk();
            n++;
        end while (tick !== 1'b1 && n < lim);
        if (tick !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL wait_tick: no tick within %0d cycles", lim);
        end
    endtask

    task automatic async_reset();
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        chk("async_rst_value", int'(value), 0);
        chk("async_rst_tick", int'(tick), 0);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int cnt_t;
        int v0;
        int exp_v;

        reset = 1'b1; enable = 1'b0; speed = 2'b00; up = 1'b1;
        load = 1'b0; load_val = 4'h0;
        model_reset();
        #7;
        chk("reset_value", int'(value), 0);
        chk("reset_tick", int'(tick), 0);
        reset = 1'b0;

        // ---- Reset mid-count: value=7, cnt=2 ----
        load = 1'b1; load_val = 4'h7; speed = 2'b01; enable = 1'b1; up = 1'b1;
        cyc_chk();
        load = 1'b0;
        cyc_chk();
        chk("pre_reset_value", int'(value), 7);
        speed = 2'b00;
        async_reset();
        cyc_chk(); chk("post_reset_1", int'(value), 1);
        cyc_chk(); chk("post_reset_2", int'(value), 2);
        cyc_chk(); chk("post_reset_3", int'(value), 3);

        // ---- Rate 01 from reset ----
        speed = 2'b01;
        async_reset();
        cyc_chk();
        chk("rate01_reload_tick", int'(tick), 0);
        chk("rate01_reload_value", int'(value), 0);
        cnt_t = 0;
        for (int i = 0; i < 20; i++) begin
            cyc_chk();
            if (tick === 1'b1) cnt_t++;
        end
        chk("rate01_tick_count", cnt_t, 5);
        chk("rate01_value", int'(value), 5);

        // ---- Vector table: wrap up/down and a rate-01 load ----
        tbl[0]  = '{1'b1, 4'hE, 2'b00, 1'b1, 1'b0, 4'hE, 1'b0};
        tbl[1]  = '{1'b0, 4'h0, 2'b00, 1'b1, 1'b1, 4'hF, 1'b1};
        tbl[2]  = '{1'b0, 4'h0, 2'b00, 1'b1, 1'b1, 4'h0, 1'b1};
        tbl[3]  = '{1'b0, 4'h0, 2'b00, 1'b1, 1'b1, 4'h1, 1'b1};
        tbl[4]  = '{1'b1, 4'h1, 2'b00, 1'b0, 1'b1, 4'h1, 1'b0};
        tbl[5]  = '{1'b0, 4'h0, 2'b00, 1'b0, 1'b1, 4'h0, 1'b1};
        tbl[6]  = '{1'b0, 4'h0, 2'b00, 1'b0, 1'b1, 4'hF, 1'b1};
        tbl[7]  = '{1'b0, 4'h0, 2'b00, 1'b0, 1'b1, 4'hE, 1'b1};
        tbl[8]  = '{1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 4'hE, 1'b0};
        tbl[9]  = '{1'b1, 4'h5, 2'b01, 1'b1, 1'b0, 4'h5, 1'b0};
        tbl[10] = '{1'b0, 4'h0, 2'b01, 1'b1, 1'b1, 4'h5, 1'b0};
        tbl[11] = '{1'b0, 4'h0, 2'b01, 1'b1, 1'b1, 4'h5, 1'b0};
        tbl[12] = '{1'b0, 4'h0, 2'b01, 1'b1, 1'b1, 4'h5, 1'b0};
        tbl[13] = '{1'b0, 4'h0, 2'b01, 1'b1, 1'b1, 4'h6, 1'b1};
        for (int i = 0; i < 14; i++) begin
            load = tbl[i].ld; load_val = tbl[i].lv; speed = tbl[i].spd;
            up = tbl[i].up; enable = tbl[i].en;
            clk_edge();
            chk($sformatf("vec%0d_value", i), int'(value), int'(tbl[i].ev));
            chk($sformatf("vec%0d_tick", i), int'(tick), int'(tbl[i].et));
        end
        load = 1'b0;

        // ---- Enable gating: 3 disabled cycles at cnt=1 ----
        speed = 2'b01; enable = 1'b1; up = 1'b1;
        wait_tick(20, n);
        v0 = int'(value);
        cyc_chk(); cyc_chk();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc_chk();
            chk("gated_hold", int'(value), v0);
        end
        enable = 1'b1;
        wait_tick(20, n);
        chk("gated_period", n + 5, 4 + 3);
        chk("gated_step", int'(value), (v0 + 1) % 16);

        // ---- Load on the step cycle ----
        cyc_chk(); cyc_chk(); cyc_chk();
        load = 1'b1; load_val = 4'h5;
        cyc_chk();
        chk("coll_load_value", int'(value), 5);
        chk("coll_load_tick", int'(tick), 0);
        load = 1'b0;
        wait_tick(20, n);
        chk("coll_load_next", n, 4);
        chk("coll_load_next_value", int'(value), 6);

        // ---- Speed change 01->11 on the step cycle ----
        cyc_chk(); cyc_chk(); cyc_chk();
        v0 = int'(value);
        speed = 2'b11;
        cyc_chk();
        chk("coll_speed_tick", int'(tick), 0);
        chk("coll_speed_value", int'(value), v0);
        wait_tick(40, n);
        chk("coll_speed_next", n, 16);

        // ---- Direction change mid-period at speed 10 ----
        speed = 2'b10;
        wait_tick(40, n);
        v0 = int'(value);
        cyc_chk(); cyc_chk(); cyc_chk();
        up = 1'b0;
        wait_tick(40, n);
        chk("dir_period", n + 3, 8);
        exp_v = (v0 + 15) % 16;
        chk("dir_value", int'(value), exp_v);

        // ---- Randomized run against the model ----
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) async_reset();
            load     = ($urandom_range(0, 19) == 0);
            load_val = 4'($urandom);
            if ($urandom_range(0, 29) == 0) speed = 2'($urandom);
            if ($urandom_range(0, 9) == 0)  up = ~up;
            enable   = ($urandom_range(0, 4) != 0);
            cyc_chk();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_hex_counter
`default_nettype wire
